// File: rtl/async_fifo_wr_arb.sv
// async_fifo_wr_arb: round-robin write arbiter feeding one async FIFO write port; define WR_ARB_PKT_LOCK_EN to hold the grant until the last beat of a packet
module async_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w_valid,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    input  logic                          fifo_w_ready,
    output logic [IW-1:0]                 grant_id,
    output logic                          grant_active
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t          state_q;
    logic [IW-1:0]   grant_id_q, rr_ptr_q, rr_ptr_d, pick_d, idx;
    logic            grant_active_q, busy, beat, release_d;
    // First requester at or above rr_ptr, wrapping; lowest offset wins
    always_comb begin
        pick_d = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            pick_d = req_valid[idx] ? idx : pick_d;
        end
    end
    assign busy         = state_q == BUSY;
    assign beat         = busy && req_valid[grant_id_q] && fifo_w_ready;
    assign rr_ptr_d     = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign fifo_w_valid = busy && req_valid[grant_id_q];
    assign fifo_w_data  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready    = (busy && fifo_w_ready) ? NUM_REQ'(1) << grant_id_q : '0;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
`ifdef WR_ARB_PKT_LOCK_EN
    assign release_d = beat && req_last[grant_id_q];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign release_d   = beat;
`endif
    // Grant FSM: latch a winner in IDLE, hold it in BUSY until release
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q        <= IDLE;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
            grant_active_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (|req_valid) begin
                state_q        <= BUSY;
                grant_id_q     <= pick_d;
                grant_active_q <= 1'b1;
            end
        end else if (release_d) begin
            state_q        <= IDLE;
            rr_ptr_q       <= rr_ptr_d;
            grant_active_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// tb_async_fifo_wr_arb: directed table plus hand sequences for the write arbiter
module tb_async_fifo_wr_arb;
    logic         wclk = 1'b0;
    logic         wrst;
    logic [3:0]   req_valid, req_last, req_ready;
    logic [127:0] req_data;
    logic         fifo_w_valid, fifo_w_ready, grant_active;
    logic [31:0]  fifo_w_data;
    logic [1:0]   grant_id;
    int           n_chk = 0, n_err = 0;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       fr;
        logic       ga;
        logic [1:0] gid;
        logic       fv;
        logic [31:0] fd;
        logic [3:0] rr;
    } vec_t;
    vec_t tbl[$];

    typedef struct { logic [1:0] id; logic [31:0] d; } wr_t;
    wr_t log_q[$];

    async_fifo_wr_arb dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_w_valid(fifo_w_valid),
        .fifo_w_data(fifo_w_data), .fifo_w_ready(fifo_w_ready),
        .grant_id(grant_id), .grant_active(grant_active)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] v, input logic fr, input logic ga,
                       input logic [1:0] gid, input logic fv, input logic [31:0] fd, input logic [3:0] rr);
        vec_t e;
        e.rst = rst; e.v = v; e.fr = fr; e.ga = ga; e.gid = gid; e.fv = fv; e.fd = fd; e.rr = rr;
        tbl.push_back(e);
    endtask

    initial begin
        int beats;
        logic r3_done;
        logic [1:0]  exp_id[4];
        logic [31:0] exp_d[4];
        wrst = 1'b1; req_valid = '0; req_last = 4'hF; fifo_w_ready = 1'b1;
        req_data = {32'hD3, 32'hC2, 32'hB1, 32'hA5};
        repeat (2) @(negedge wclk);
        // reset, single request from 0 (write lands the cycle after the request)
        add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 32'hA5, 4'b0001);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        // all four requesting: grants 0,1,2,3,0
        add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 32'hA5, 4'b0001);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 32'hB1, 4'b0010);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 32'hC2, 4'b0100);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 32'hD3, 4'b1000);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 32'hA5, 4'b0001);
        // requester 2 stalled by a full FIFO for 5 cycles
        add(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        for (int i = 0; i < 5; i++)
            add(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 32'hC2, 4'b0000);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 32'hC2, 4'b0100);
        // rr_ptr=3 with 1001: grant 3 then wrap to 0
        add(1'b0, 4'b1001, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1001, 1'b1, 1'b1, 2'd3, 1'b1, 32'hD3, 4'b1000);
        add(1'b0, 4'b1001, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b1, 32'hA5, 4'b0001);
        // granted requester drops valid: grant holds; requester 3 ignored while busy
        add(1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,  4'b0010);
        add(1'b0, 4'b1000, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,  4'b0010);
        add(1'b0, 4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 32'hB1, 4'b0010);
        add(1'b0, 4'b1000, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0,  4'b0000);
        add(1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 32'hD3, 4'b1000);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0,  4'b0000);
        foreach (tbl[i]) begin
            @(negedge wclk);
            wrst = tbl[i].rst; req_valid = tbl[i].v; fifo_w_ready = tbl[i].fr;
            #1;
            check($sformatf("row%0d_grant_active", i), 32'(grant_active), 32'(tbl[i].ga));
            check($sformatf("row%0d_grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
            check($sformatf("row%0d_fifo_w_valid", i), 32'(fifo_w_valid), 32'(tbl[i].fv));
            check($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].rr));
            if (tbl[i].fv) check($sformatf("row%0d_fifo_w_data", i), fifo_w_data, tbl[i].fd);
        end
        // reset mid-packet: rr_ptr moved to 2, then requester 3 stalled, then reset
        @(negedge wclk); req_valid = 4'b0010; fifo_w_ready = 1'b1;
        @(negedge wclk); #1;
        check("pre_grant1", 32'(grant_id), 32'd1);
        @(negedge wclk); req_valid = 4'b1000; fifo_w_ready = 1'b0;
        @(negedge wclk); #1;
        check("stall_grant3", 32'(grant_id), 32'd3);
        check("stall_active", 32'(grant_active), 32'd1);
        wrst = 1'b1;
        @(negedge wclk); #1;
        check("rst_active", 32'(grant_active), 32'd0);
        check("rst_fifo_w_valid", 32'(fifo_w_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        wrst = 1'b0; req_valid = 4'b1001; fifo_w_ready = 1'b1;
        #1;
        check("post_rst_idle_valid", 32'(fifo_w_valid), 32'd0);
        @(negedge wclk); #1;
        check("post_rst_grant0", 32'(grant_id), 32'd0);
        check("post_rst_data", fifo_w_data, 32'hA5);
        // packet sequence: requester 1 sends 3 beats while requester 3 waits
        beats = 0; r3_done = 1'b0;
        for (int c = 0; c < 20 && !(beats == 3 && r3_done); c++) begin
            @(negedge wclk);
            req_valid = {!r3_done, 1'b0, beats < 3, 1'b0};
            req_last  = {1'b1, 1'b0, beats == 2, 1'b0};
            req_data[63:32] = 32'h100 + 32'(beats);
            #1;
            if (fifo_w_valid && fifo_w_ready) begin
                log_q.push_back('{grant_id, fifo_w_data});
                if (grant_id == 2'd1) beats++;
                if (grant_id == 2'd3) r3_done = 1'b1;
            end
        end
        check("pkt_done", 32'(beats == 3 && r3_done), 32'd1);
`ifdef WR_ARB_PKT_LOCK_EN
        exp_id = '{2'd1, 2'd1, 2'd1, 2'd3};
        exp_d  = '{32'h100, 32'h101, 32'h102, 32'hD3};
`else
        exp_id = '{2'd1, 2'd3, 2'd1, 2'd1};
        exp_d  = '{32'h100, 32'hD3, 32'h101, 32'h102};
`endif
        check("pkt_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check($sformatf("pkt_w%0d_id", i), 32'(log_q[i].id), 32'(exp_id[i]));
            check($sformatf("pkt_w%0d_data", i), log_q[i].d, exp_d[i]);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
